// File: rtl/mem_pkg.sv
// Shared opcodes, FSM/width enums and lane helpers for the data-memory access sequencer.
package mem_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [2:0] {IDLE, RD, WR, DONE, HOLD} state_e;
  typedef enum logic [1:0] {BYTE, HALF, WORD} width_e;

  typedef struct packed {
    width_e width;
    logic   is_signed;
  } access_t;

  // Unlisted load opcodes fall back to a full word.
  function automatic access_t decode_load(input logic [5:0] op);
    access_t a;
    case (op)
      OP_LB:   a = '{width: BYTE, is_signed: 1'b1};
      OP_LH:   a = '{width: HALF, is_signed: 1'b1};
      OP_LBU:  a = '{width: BYTE, is_signed: 1'b0};
      OP_LHU:  a = '{width: HALF, is_signed: 1'b0};
      default: a = '{width: WORD, is_signed: 1'b0};
    endcase
    return a;
  endfunction

  function automatic access_t decode_store(input logic [5:0] op);
    access_t a;
    case (op)
      OP_SB:   a = '{width: BYTE, is_signed: 1'b0};
      OP_SH:   a = '{width: HALF, is_signed: 1'b0};
      default: a = '{width: WORD, is_signed: 1'b0};
    endcase
    return a;
  endfunction

  function automatic logic [3:0] lanes(input width_e w, input logic [1:0] off);
    case (w)
      BYTE:    return 4'b0001 << off;
      HALF:    return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] replicate(input width_e w, input logic [31:0] d);
    case (w)
      BYTE:    return {4{d[7:0]}};
      HALF:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane select plus sign/zero extension of bus read data.
module load_extract
  import mem_pkg::*;
(
  input  logic [31:0] readdata,
  input  width_e      width,
  input  logic        is_signed,
  input  logic [1:0]  byte_off,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = readdata[{byte_off, 3'b000} +: 8];
    sel_half = readdata[{byte_off[1], 4'b0000} +: 16];
    case (width)
      BYTE:    data = {{24{is_signed & sel_byte[7]}}, sel_byte};
      HALF:    data = {{16{is_signed & sel_half[15]}}, sel_half};
      default: data = readdata;
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Runs one Avalon-style data-bus transaction per MemRead/MemWrite level request.
// Optional MEM_ALIGN_CHECK_EN adds the align_err port and skips misaligned accesses.
module mem_access_sequencer
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] load_data,
  output logic        end_of_inst_reg,
  output logic        end_of_inst_store
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        align_err
`endif
);

  state_e      state_q, state_d;
  width_e      width_q, width_d;
  logic        signed_q, signed_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] address_q, address_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] load_data_q, load_data_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        eoi_reg_q, eoi_reg_d;
  logic        eoi_store_q, eoi_store_d;
  access_t     acc;
  logic [31:0] extracted;
`ifdef MEM_ALIGN_CHECK_EN
  logic        align_err_q, align_err_d;
  logic        misaligned;
`endif

  load_extract u_load_extract (
    .readdata  (avm_readdata),
    .width     (width_q),
    .is_signed (signed_q),
    .byte_off  (off_q),
    .data      (extracted)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can leave it unassigned (no latches).
    state_d     = state_q;
    width_d     = width_q;
    signed_d    = signed_q;
    off_d       = off_q;
    address_d   = address_q;
    writedata_d = writedata_q;
    be_d        = be_q;
    load_data_d = load_data_q;
    read_d      = 1'b0;
    write_d     = 1'b0;
    eoi_reg_d   = 1'b0;
    eoi_store_d = 1'b0;
    acc         = mem_read ? decode_load(opcode) : decode_store(opcode);
`ifdef MEM_ALIGN_CHECK_EN
    align_err_d = 1'b0;
    misaligned  = (acc.width == HALF && addr[0]) || (acc.width == WORD && addr[1:0] != 2'b00);
`endif

    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          width_d   = acc.width;
          signed_d  = acc.is_signed;
          off_d     = addr[1:0];
          address_d = {addr[31:2], 2'b00};
          be_d      = lanes(acc.width, addr[1:0]);
          if (!mem_read) writedata_d = replicate(acc.width, store_data);
`ifdef MEM_ALIGN_CHECK_EN
          if (misaligned) begin
            state_d     = DONE;
            align_err_d = 1'b1;
            eoi_reg_d   = mem_read;
            eoi_store_d = !mem_read;
          end else
`endif
          begin
            state_d = mem_read ? RD : WR;
            read_d  = mem_read;
            write_d = !mem_read;
          end
        end
      end
      RD: begin
        if (avm_waitrequest) begin
          read_d = 1'b1;
        end else begin
          state_d     = DONE;
          load_data_d = extracted;
          eoi_reg_d   = 1'b1;
        end
      end
      WR: begin
        if (avm_waitrequest) begin
          write_d = 1'b1;
        end else begin
          state_d     = DONE;
          eoi_store_d = 1'b1;
        end
      end
      DONE: state_d = HOLD;
      // Wait for both level requests to drop so a lingering request cannot retrigger.
      HOLD: if (!mem_read && !mem_write) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the async reset clears every register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      width_q     <= BYTE;
      signed_q    <= 1'b0;
      off_q       <= 2'b00;
      address_q   <= '0;
      writedata_q <= '0;
      be_q        <= '0;
      load_data_q <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      eoi_reg_q   <= 1'b0;
      eoi_store_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      align_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      signed_q    <= signed_d;
      off_q       <= off_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      be_q        <= be_d;
      load_data_q <= load_data_d;
      read_q      <= read_d;
      write_q     <= write_d;
      eoi_reg_q   <= eoi_reg_d;
      eoi_store_q <= eoi_store_d;
`ifdef MEM_ALIGN_CHECK_EN
      align_err_q <= align_err_d;
`endif
    end
  end

  assign avm_address       = address_q;
  assign avm_read          = read_q;
  assign avm_write         = write_q;
  assign avm_writedata     = writedata_q;
  assign avm_byteenable    = be_q;
  assign load_data         = load_data_q;
  assign end_of_inst_reg   = eoi_reg_q;
  assign end_of_inst_store = eoi_store_q;
`ifdef MEM_ALIGN_CHECK_EN
  assign align_err         = align_err_q;
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed plus randomized bench for mem_access_sequencer against a transaction-level model.
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [5:0]  opcode;
  logic [31:0] addr, store_data;
  logic [31:0] avm_address, avm_writedata, avm_readdata, load_data;
  logic        avm_read, avm_write, avm_waitrequest;
  logic [3:0]  avm_byteenable;
  logic        end_of_inst_reg, end_of_inst_store;
`ifdef MEM_ALIGN_CHECK_EN
  logic        align_err;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_load_data = 32'h0;

  always #5 clk = ~clk;

  mem_access_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .opcode            (opcode),
    .addr              (addr),
    .store_data        (store_data),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .load_data         (load_data),
    .end_of_inst_reg   (end_of_inst_reg),
    .end_of_inst_store (end_of_inst_store)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .align_err         (align_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".read"}, 32'(avm_read), 32'd0);
    check({tag, ".write"}, 32'(avm_write), 32'd0);
    check({tag, ".eoi_reg"}, 32'(end_of_inst_reg), 32'd0);
    check({tag, ".eoi_store"}, 32'(end_of_inst_store), 32'd0);
  endtask

  // Model: byte count of the access, from the opcode tables.
  function automatic int access_bytes(input bit is_load, input logic [5:0] op);
    if (is_load) begin
      if (op == 6'b100000 || op == 6'b100100) return 1;
      if (op == 6'b100001 || op == 6'b100101) return 2;
      return 4;
    end
    if (op == 6'b101000) return 1;
    if (op == 6'b101001) return 2;
    return 4;
  endfunction

  // One full transaction from IDLE; returns with the DUT back in IDLE unless keep_req is set.
  task automatic do_txn(input string tag, input bit is_load, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                        input int waits, input bit keep_req);
    int          nb;
    int          off;
    bit          sgn;
    bit          mis;
    logic [31:0] exp_wd, exp_ld, v;
    logic [3:0]  exp_be;
    nb  = access_bytes(is_load, op);
    sgn = is_load && (op == 6'b100000 || op == 6'b100001);
    off = (nb == 1) ? int'(a % 4) : (nb == 2) ? int'((a / 2) % 2) * 2 : 0;
    exp_be = (nb == 1) ? 4'(1 << off) : (nb == 2) ? 4'(3 << off) : 4'hF;
    exp_wd = (nb == 1) ? sd[7:0] * 32'h01010101 : (nb == 2) ? sd[15:0] * 32'h00010001 : sd;
    v = (rdata >> (8 * off));
    if (nb == 1) begin
      v = v & 32'hFF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (nb == 2) begin
      v = v & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF0000;
    end
    exp_ld = v;
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (nb == 2 && a % 2 != 0) || (nb == 4 && a % 4 != 0);
`endif

    @(negedge clk);
    mem_read   = is_load;
    mem_write  = !is_load;
    opcode     = op;
    addr       = a;
    store_data = sd;
    @(posedge clk);
    if (!mis) begin
      for (int i = 0; i <= waits; i++) begin
        @(negedge clk);
        check({tag, ".read"}, 32'(avm_read), 32'(is_load));
        check({tag, ".write"}, 32'(avm_write), 32'(!is_load));
        check({tag, ".addr"}, avm_address, a & 32'hFFFFFFFC);
        if (!is_load) begin
          check({tag, ".be"}, 32'(avm_byteenable), 32'(exp_be));
          check({tag, ".wdata"}, avm_writedata, exp_wd);
        end
        check({tag, ".early_done"}, 32'(end_of_inst_reg | end_of_inst_store), 32'd0);
        avm_waitrequest = (i < waits);
        avm_readdata    = (i < waits) ? $urandom : rdata;
        @(posedge clk);
      end
      if (is_load) exp_load_data = exp_ld;
    end
    @(negedge clk);
    avm_waitrequest = 1'b0;
    check({tag, ".eoi_reg"}, 32'(end_of_inst_reg), 32'(is_load));
    check({tag, ".eoi_store"}, 32'(end_of_inst_store), 32'(!is_load));
    check({tag, ".load_data"}, load_data, exp_load_data);
    check({tag, ".strobe_off"}, 32'(avm_read | avm_write), 32'd0);
`ifdef MEM_ALIGN_CHECK_EN
    check({tag, ".align_err"}, 32'(align_err), 32'(mis));
`endif
    if (!keep_req) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_quiet({tag, ".after"});
    @(posedge clk);
  endtask

  initial begin
    logic [5:0] load_ops [8];
    logic [5:0] store_ops [5];
    load_ops  = '{6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100010, 6'b100110, 6'b100111};
    store_ops = '{6'b101000, 6'b101001, 6'b101011, 6'b101010, 6'b101110};

    reset = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    opcode = '0;
    addr = '0;
    store_data = '0;
    avm_waitrequest = 1'b0;
    avm_readdata = '0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check("reset.addr", avm_address, 32'd0);
    check("reset.be", 32'(avm_byteenable), 32'd0);
    check("reset.wdata", avm_writedata, 32'd0);
    check("reset.load_data", load_data, 32'd0);
    reset = 1'b0;
    @(posedge clk);

    do_txn("lw_0x100", 1'b1, 6'b100011, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    do_txn("lb_0x203", 1'b1, 6'b100000, 32'h203, 32'h0, 32'h80123456, 0, 1'b0);
    do_txn("lbu_0x203", 1'b1, 6'b100100, 32'h203, 32'h0, 32'h80123456, 1, 1'b0);
    do_txn("sh_0x302", 1'b0, 6'b101001, 32'h302, 32'h1234ABCD, 32'h0, 3, 1'b0);

    // Level request held past completion must not start a second transaction.
    do_txn("held_rd", 1'b1, 6'b100011, 32'h440, 32'h0, 32'hCAFEF00D, 1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet("held_rd.hold");
      @(posedge clk);
    end
    @(negedge clk);
    mem_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_quiet("held_rd.released");
    @(posedge clk);
    do_txn("rearm_rd", 1'b1, 6'b100101, 32'h446, 32'h0, 32'h9ABC1234, 0, 1'b0);

    // Asynchronous reset in the middle of a stalled read.
    @(negedge clk);
    mem_read = 1'b1;
    opcode = 6'b100011;
    addr = 32'h500;
    @(posedge clk);
    @(negedge clk);
    avm_waitrequest = 1'b1;
    check("rst_mid.read_before", 32'(avm_read), 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    mem_read = 1'b0;
    #1;
    check_quiet("rst_mid.now");
    check("rst_mid.load_data", load_data, 32'd0);
    exp_load_data = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_quiet("rst_mid.after");
    end
    @(posedge clk);
    do_txn("post_rst_sw", 1'b0, 6'b101011, 32'h600, 32'h11223344, 32'h0, 0, 1'b0);

`ifdef MEM_ALIGN_CHECK_EN
    do_txn("align_lw", 1'b1, 6'b100011, 32'h101, 32'h0, 32'h0, 0, 1'b0);
    do_txn("align_sh", 1'b0, 6'b101001, 32'h203, 32'h55AA55AA, 32'h0, 0, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      bit          ld;
      logic [5:0]  op;
      ld = ($urandom_range(0, 1) == 1);
      op = ld ? load_ops[$urandom_range(0, 7)] : store_ops[$urandom_range(0, 4)];
      do_txn("rand", ld, op, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
